// File: rtl/ram_arbiter_if.sv
// Bundles the fetch, load/store and shared RAM port signals of ram_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_arbiter_if;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_flush_i;
  logic        if_gnt_o;
  logic        if_valid_o;
  logic [63:0] if_rdata_o;

  logic        ls_req_i;
  logic        ls_wen_i;
  logic [63:0] ls_addr_i;
  logic [63:0] ls_wdata_i;
  logic [7:0]  ls_wmask_i;
  logic [2:0]  ls_size_i;
  logic        ls_gnt_o;
  logic        ls_valid_o;
  logic [63:0] ls_rdata_o;

  logic        ram_rw_cen_o;
  logic        ram_rw_wen_o;
  logic [63:0] ram_rw_addr_o;
  logic [63:0] ram_rw_wdata_o;
  logic [7:0]  ram_rw_wmask_o;
  logic [2:0]  ram_rw_size_o;
  logic        ram_rw_ready_i;
  logic [63:0] ram_rw_data_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_valid_o, if_rdata_o,
    input  ls_req_i, ls_wen_i, ls_addr_i, ls_wdata_i, ls_wmask_i, ls_size_i,
    output ls_gnt_o, ls_valid_o, ls_rdata_o,
    output ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o,
    output ram_rw_wmask_o, ram_rw_size_o,
    input  ram_rw_ready_i, ram_rw_data_i
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_valid_o, if_rdata_o,
    output ls_req_i, ls_wen_i, ls_addr_i, ls_wdata_i, ls_wmask_i, ls_size_i,
    input  ls_gnt_o, ls_valid_o, ls_rdata_o,
    input  ram_rw_cen_o, ram_rw_wen_o, ram_rw_addr_o, ram_rw_wdata_o,
    input  ram_rw_wmask_o, ram_rw_size_o,
    output ram_rw_ready_i, ram_rw_data_i
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one RAM port between instruction fetch and load/store, one transaction in flight.
// Define RAM_ARB_RR_EN for round-robin conflict resolution; default is LSU-over-IFU priority.
module ram_arbiter #(
  parameter logic [2:0] IF_SIZE = 3'd2
) (
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e      state_q;
  logic        owner_ls_q;
  logic        last_ls_q;
  logic        wen_q;
  logic        cen_q;
  logic        ram_wen_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [2:0]  size_q;
  logic        flushed_q;
  logic        if_valid_q;
  logic        ls_valid_q;
  logic [63:0] resp_data_q;
  logic [63:0] if_rdata_q;
  logic [63:0] ls_rdata_q;

  logic        if_gnt;
  logic        ls_gnt;

  // Grant is combinational so the requester sees it in the cycle it is accepted.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (bus.if_req_i && bus.ls_req_i) begin
`ifdef RAM_ARB_RR_EN
        if (last_ls_q) begin
          if_gnt = 1'b1;
        end else begin
          ls_gnt = 1'b1;
        end
`else
        ls_gnt = 1'b1;
`endif
      end else begin
        if_gnt = bus.if_req_i;
        ls_gnt = bus.ls_req_i;
      end
    end else begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
    end
  end

  // Transaction FSM with all RAM-side and response outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_ls_q  <= 1'b0;
      last_ls_q   <= 1'b0;
      wen_q       <= 1'b0;
      cen_q       <= 1'b0;
      ram_wen_q   <= 1'b0;
      addr_q      <= 64'h0;
      wdata_q     <= 64'h0;
      wmask_q     <= 8'h00;
      size_q      <= 3'd0;
      flushed_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      ls_valid_q  <= 1'b0;
      resp_data_q <= 64'h0;
      if_rdata_q  <= 64'h0;
      ls_rdata_q  <= 64'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ls_gnt) begin
            owner_ls_q <= 1'b1;
            last_ls_q  <= 1'b1;
            wen_q      <= bus.ls_wen_i;
            ram_wen_q  <= bus.ls_wen_i;
            addr_q     <= bus.ls_addr_i;
            wdata_q    <= bus.ls_wdata_i;
            wmask_q    <= bus.ls_wmask_i;
            size_q     <= bus.ls_size_i;
            flushed_q  <= 1'b0;
            cen_q      <= 1'b1;
            state_q    <= ISSUE;
          end else if (if_gnt) begin
            owner_ls_q <= 1'b0;
            last_ls_q  <= 1'b0;
            wen_q      <= 1'b0;
            ram_wen_q  <= 1'b0;
            addr_q     <= bus.if_addr_i;
            wdata_q    <= 64'h0;
            wmask_q    <= 8'h00;
            size_q     <= IF_SIZE;
            flushed_q  <= bus.if_flush_i;
            cen_q      <= 1'b1;
            state_q    <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          cen_q     <= 1'b0;
          ram_wen_q <= 1'b0;
          flushed_q <= flushed_q | bus.if_flush_i;
          state_q   <= WAIT;
        end
        WAIT: begin
          flushed_q <= flushed_q | bus.if_flush_i;
          if (bus.ram_rw_ready_i) begin
            if (owner_ls_q) begin
              ls_valid_q <= 1'b1;
              if (!wen_q) begin
                ls_rdata_q <= bus.ram_rw_data_i;
              end else begin
                ls_rdata_q <= ls_rdata_q;
              end
            end else begin
              resp_data_q <= bus.ram_rw_data_i;
              if_valid_q  <= ~(flushed_q | bus.if_flush_i);
            end
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          // A flush arriving in the response cycle still cancels the fetch result.
          if (if_valid_q && !bus.if_flush_i) begin
            if_rdata_q <= resp_data_q;
          end else begin
            if_rdata_q <= if_rdata_q;
          end
          if_valid_q <= 1'b0;
          ls_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt_o       = if_gnt;
  assign bus.ls_gnt_o       = ls_gnt;
  assign bus.ram_rw_cen_o   = cen_q;
  assign bus.ram_rw_wen_o   = ram_wen_q;
  assign bus.ram_rw_addr_o  = addr_q;
  assign bus.ram_rw_wdata_o = wdata_q;
  assign bus.ram_rw_wmask_o = wmask_q;
  assign bus.ram_rw_size_o  = size_q;
  assign bus.if_valid_o     = if_valid_q & ~bus.if_flush_i;
  assign bus.if_rdata_o     = (if_valid_q && !bus.if_flush_i) ? resp_data_q : if_rdata_q;
  assign bus.ls_valid_o     = ls_valid_q;
  assign bus.ls_rdata_o     = ls_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, directed corner cases and
// a randomized run against a transaction-level timing model.
module tb_ram_arbiter;

  localparam logic [2:0]  IF_SZ = 3'd2;
  localparam logic [63:0] FD    = 64'h0000_0013_0000_0093;
  localparam logic [63:0] IA    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] LA    = 64'h0000_0000_9000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_arbiter_if bus();
  ram_arbiter #(.IF_SIZE(IF_SZ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nchecks = 0;
  int nerrors = 0;

  typedef struct {
    bit          ir, lr, rdy;
    bit          e_ig, e_lg, e_cen, e_iv, e_lv, chk_a;
    logic [63:0] e_addr;
  } vec_t;

  vec_t tbl[16];
  bit   win_ls[3];

  task automatic chk1(input string name, input logic act, input logic exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_req_i       = 1'b0;
    bus.if_addr_i      = 64'h0;
    bus.if_flush_i     = 1'b0;
    bus.ls_req_i       = 1'b0;
    bus.ls_wen_i       = 1'b0;
    bus.ls_addr_i      = 64'h0;
    bus.ls_wdata_i     = 64'h0;
    bus.ls_wmask_i     = 8'h00;
    bus.ls_size_i      = 3'd0;
    bus.ram_rw_ready_i = 1'b0;
    bus.ram_rw_data_i  = 64'h0;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, " if_gnt"}, bus.if_gnt_o, 1'b0);
    chk1({tag, " ls_gnt"}, bus.ls_gnt_o, 1'b0);
    chk1({tag, " cen"}, bus.ram_rw_cen_o, 1'b0);
    chk1({tag, " wen"}, bus.ram_rw_wen_o, 1'b0);
    chk64({tag, " addr"}, bus.ram_rw_addr_o, 64'h0);
    chk64({tag, " wdata"}, bus.ram_rw_wdata_o, 64'h0);
    chk64({tag, " wmask"}, {56'h0, bus.ram_rw_wmask_o}, 64'h0);
    chk64({tag, " size"}, {61'h0, bus.ram_rw_size_o}, 64'h0);
    chk1({tag, " if_valid"}, bus.if_valid_o, 1'b0);
    chk1({tag, " ls_valid"}, bus.ls_valid_o, 1'b0);
    chk64({tag, " if_rdata"}, bus.if_rdata_o, 64'h0);
    chk64({tag, " ls_rdata"}, bus.ls_rdata_o, 64'h0);
  endtask

  // Reset with both requests asserted: no grant may escape while rst_n is low.
  task automatic do_reset();
    idle_inputs();
    rst_n          = 1'b0;
    bus.if_req_i   = 1'b1;
    bus.ls_req_i   = 1'b1;
    next();
    mid();
    check_zero("reset");
    rst_n = 1'b1;
    idle_inputs();
    next();
  endtask

  function automatic vec_t mk(bit ir, bit lr, bit rdy, bit ig, bit lg, bit cen,
                              bit iv, bit lv, bit ca, logic [63:0] a);
    vec_t v;
    v.ir = ir; v.lr = lr; v.rdy = rdy;
    v.e_ig = ig; v.e_lg = lg; v.e_cen = cen; v.e_iv = iv; v.e_lv = lv;
    v.chk_a = ca; v.e_addr = a;
    return v;
  endfunction

  // Random-phase model state
  bit          ir, lr, act, t_ls, t_wen, t_flush, t_rdy, last_ls, fl, rdy;
  int          t_g, t_r, cen_cnt;
  logic [63:0] t_data, m_addr, m_wdata, m_ifrd, m_lsrd, e_ifrd, dat;
  logic [7:0]  m_wmask;
  logic [2:0]  m_size;
  bit          e_ig, e_lg, e_cen, e_wen, e_resp, e_iv, e_lv;

  initial begin
    rst_n = 1'b1;
    idle_inputs();

    // Single fetch, then three back-to-back conflicts with both requests held.
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tbl[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, IA);
    tbl[2] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tbl[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
`ifdef RAM_ARB_RR_EN
    win_ls[0] = 1'b1; win_ls[1] = 1'b0; win_ls[2] = 1'b1;
`else
    win_ls[0] = 1'b1; win_ls[1] = 1'b1; win_ls[2] = 1'b1;
`endif
    for (int t = 0; t < 3; t++) begin
      tbl[4 + 4 * t] = mk(1'b1, 1'b1, 1'b0, !win_ls[t], win_ls[t], 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      tbl[5 + 4 * t] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, win_ls[t] ? LA : IA);
      tbl[6 + 4 * t] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      tbl[7 + 4 * t] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, !win_ls[t], win_ls[t], 1'b0, 64'h0);
    end

    do_reset();
    bus.if_addr_i     = IA;
    bus.ls_addr_i     = LA;
    bus.ls_size_i     = 3'd3;
    bus.ram_rw_data_i = FD;
    for (int i = 0; i < 16; i++) begin
      bus.if_req_i       = tbl[i].ir;
      bus.ls_req_i       = tbl[i].lr;
      bus.ram_rw_ready_i = tbl[i].rdy;
      mid();
      chk1($sformatf("tbl%0d if_gnt", i), bus.if_gnt_o, tbl[i].e_ig);
      chk1($sformatf("tbl%0d ls_gnt", i), bus.ls_gnt_o, tbl[i].e_lg);
      chk1($sformatf("tbl%0d cen", i), bus.ram_rw_cen_o, tbl[i].e_cen);
      chk1($sformatf("tbl%0d if_valid", i), bus.if_valid_o, tbl[i].e_iv);
      chk1($sformatf("tbl%0d ls_valid", i), bus.ls_valid_o, tbl[i].e_lv);
      if (tbl[i].chk_a) begin
        chk64($sformatf("tbl%0d addr", i), bus.ram_rw_addr_o, tbl[i].e_addr);
        chk1($sformatf("tbl%0d wen", i), bus.ram_rw_wen_o, 1'b0);
      end
      if (tbl[i].e_iv) chk64($sformatf("tbl%0d if_rdata", i), bus.if_rdata_o, FD);
      if (tbl[i].e_lv) chk64($sformatf("tbl%0d ls_rdata", i), bus.ls_rdata_o, FD);
      next();
    end
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;

    // Store: full-mask write, response strobe without touching ls_rdata.
    bus.ls_req_i   = 1'b1;
    bus.ls_wen_i   = 1'b1;
    bus.ls_addr_i  = 64'h0000_0000_8000_0100;
    bus.ls_wdata_i = 64'h1122_3344_5566_7788;
    bus.ls_wmask_i = 8'hFF;
    bus.ls_size_i  = 3'd3;
    mid(); chk1("store gnt", bus.ls_gnt_o, 1'b1);
    next(); bus.ls_req_i = 1'b0; bus.ls_wen_i = 1'b0;
    mid();
    chk1("store cen", bus.ram_rw_cen_o, 1'b1);
    chk1("store wen", bus.ram_rw_wen_o, 1'b1);
    chk64("store addr", bus.ram_rw_addr_o, 64'h0000_0000_8000_0100);
    chk64("store wdata", bus.ram_rw_wdata_o, 64'h1122_3344_5566_7788);
    chk64("store wmask", {56'h0, bus.ram_rw_wmask_o}, 64'hFF);
    next(); bus.ram_rw_ready_i = 1'b1; bus.ram_rw_data_i = 64'hDEAD_BEEF_0BAD_F00D;
    mid(); chk1("store cen drop", bus.ram_rw_cen_o, 1'b0);
    next(); bus.ram_rw_ready_i = 1'b0;
    mid();
    chk1("store ls_valid", bus.ls_valid_o, 1'b1);
    chk64("store ls_rdata", bus.ls_rdata_o, FD);
    next();
    mid(); chk1("store valid once", bus.ls_valid_o, 1'b0);
    next();

    // Flush during WAIT: access still issued once, response dropped.
    cen_cnt = 0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h0000_0000_8000_0040;
    mid(); chk1("flush gnt", bus.if_gnt_o, 1'b1); cen_cnt += int'(bus.ram_rw_cen_o);
    next(); bus.if_req_i = 1'b0;
    mid(); cen_cnt += int'(bus.ram_rw_cen_o);
    next(); bus.if_flush_i = 1'b1;
    mid(); cen_cnt += int'(bus.ram_rw_cen_o);
    next(); bus.if_flush_i = 1'b0; bus.ram_rw_ready_i = 1'b1; bus.ram_rw_data_i = 64'h0000_0000_0000_AAAA;
    mid(); cen_cnt += int'(bus.ram_rw_cen_o);
    next(); bus.ram_rw_ready_i = 1'b0;
    mid(); cen_cnt += int'(bus.ram_rw_cen_o);
    chk1("flush if_valid", bus.if_valid_o, 1'b0);
    chk64("flush if_rdata", bus.if_rdata_o, FD);
    chk64("flush cen count", 64'(cen_cnt), 64'd1);
    next();
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h0000_0000_8000_0080;
    mid(); chk1("postflush gnt", bus.if_gnt_o, 1'b1);
    next(); bus.if_req_i = 1'b0;
    mid(); chk64("postflush addr", bus.ram_rw_addr_o, 64'h0000_0000_8000_0080);
    next(); bus.ram_rw_ready_i = 1'b1; bus.ram_rw_data_i = 64'h0000_0000_0000_BBBB;
    mid();
    next(); bus.ram_rw_ready_i = 1'b0;
    mid();
    chk1("postflush if_valid", bus.if_valid_o, 1'b1);
    chk64("postflush if_rdata", bus.if_rdata_o, 64'h0000_0000_0000_BBBB);
    next();

    // Reset while waiting for the RAM: late ready must be ignored.
    bus.if_req_i = 1'b1; bus.if_addr_i = IA;
    mid(); chk1("rstwait gnt", bus.if_gnt_o, 1'b1);
    next(); bus.if_req_i = 1'b0;
    mid();
    next(); rst_n = 1'b0;
    mid(); chk1("rstwait gnt low", bus.if_gnt_o, 1'b0);
    next(); rst_n = 1'b1; bus.ram_rw_ready_i = 1'b1; bus.ram_rw_data_i = 64'h0000_0000_0000_CCCC;
    mid(); check_zero("rstwait");
    next(); bus.ram_rw_ready_i = 1'b0; bus.if_req_i = 1'b1;
    mid();
    chk1("rstwait no if_valid", bus.if_valid_o, 1'b0);
    chk64("rstwait if_rdata", bus.if_rdata_o, 64'h0);
    chk1("rstwait idle gnt", bus.if_gnt_o, 1'b1);
    next(); bus.if_req_i = 1'b0;

    // Delayed ready: five stalled WAIT cycles with a competing fetch pending.
    do_reset();
    bus.ls_req_i = 1'b1; bus.ls_wen_i = 1'b0; bus.ls_addr_i = LA;
    mid(); chk1("delay gnt", bus.ls_gnt_o, 1'b1);
    next(); bus.ls_req_i = 1'b0;
    mid(); chk1("delay cen", bus.ram_rw_cen_o, 1'b1);
    next(); bus.if_req_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk1($sformatf("delay%0d if_gnt", k), bus.if_gnt_o, 1'b0);
      chk1($sformatf("delay%0d cen", k), bus.ram_rw_cen_o, 1'b0);
      chk1($sformatf("delay%0d ls_valid", k), bus.ls_valid_o, 1'b0);
      next();
    end
    bus.ram_rw_ready_i = 1'b1; bus.ram_rw_data_i = 64'h0123_4567_89AB_CDEF;
    mid(); chk1("delay rdy gnt", bus.if_gnt_o, 1'b0);
    next(); bus.ram_rw_ready_i = 1'b0;
    mid();
    chk1("delay ls_valid", bus.ls_valid_o, 1'b1);
    chk64("delay ls_rdata", bus.ls_rdata_o, 64'h0123_4567_89AB_CDEF);
    chk1("delay resp gnt", bus.if_gnt_o, 1'b0);
    next();
    mid(); chk1("delay idle gnt", bus.if_gnt_o, 1'b1);
    next();

    // Randomized run against a timestamp-based transaction model.
    do_reset();
    ir = 1'b0; lr = 1'b0; act = 1'b0; last_ls = 1'b0;
    t_ls = 1'b0; t_wen = 1'b0; t_flush = 1'b0; t_rdy = 1'b0; t_g = 0; t_r = 0;
    t_data = 64'h0; m_addr = 64'h0; m_wdata = 64'h0; m_wmask = 8'h00; m_size = 3'd0;
    m_ifrd = 64'h0; m_lsrd = 64'h0;
    for (int c = 0; c < 4000; c++) begin
      if (!ir && ($urandom_range(0, 99) < 35)) begin
        ir = 1'b1;
        bus.if_addr_i = {$urandom, $urandom};
      end
      if (!lr && ($urandom_range(0, 99) < 35)) begin
        lr = 1'b1;
        bus.ls_wen_i   = 1'($urandom_range(0, 1));
        bus.ls_addr_i  = {$urandom, $urandom};
        bus.ls_wdata_i = {$urandom, $urandom};
        bus.ls_wmask_i = 8'($urandom);
        bus.ls_size_i  = 3'($urandom_range(0, 7));
      end
      fl  = ($urandom_range(0, 99) < 15);
      rdy = ($urandom_range(0, 99) < 40);
      dat = {$urandom, $urandom};
      bus.if_req_i = ir; bus.ls_req_i = lr; bus.if_flush_i = fl;
      bus.ram_rw_ready_i = rdy; bus.ram_rw_data_i = dat;
      mid();

      e_cen  = act && (c == t_g + 1);
      e_wen  = e_cen && t_wen;
      e_resp = act && t_rdy && (c == t_r + 1);
      e_iv   = e_resp && !t_ls && !t_flush && !fl;
      e_lv   = e_resp && t_ls;
      e_ifrd = e_iv ? t_data : m_ifrd;
      e_ig = 1'b0; e_lg = 1'b0;
      if (!act) begin
        if (ir && lr) begin
`ifdef RAM_ARB_RR_EN
          if (last_ls) e_ig = 1'b1; else e_lg = 1'b1;
`else
          e_lg = 1'b1;
`endif
        end else begin
          e_ig = ir; e_lg = lr;
        end
      end
      chk1($sformatf("rnd%0d if_gnt", c), bus.if_gnt_o, e_ig);
      chk1($sformatf("rnd%0d ls_gnt", c), bus.ls_gnt_o, e_lg);
      chk1($sformatf("rnd%0d cen", c), bus.ram_rw_cen_o, e_cen);
      chk1($sformatf("rnd%0d wen", c), bus.ram_rw_wen_o, e_wen);
      chk64($sformatf("rnd%0d addr", c), bus.ram_rw_addr_o, m_addr);
      chk64($sformatf("rnd%0d wdata", c), bus.ram_rw_wdata_o, m_wdata);
      chk64($sformatf("rnd%0d wmask", c), {56'h0, bus.ram_rw_wmask_o}, {56'h0, m_wmask});
      chk64($sformatf("rnd%0d size", c), {61'h0, bus.ram_rw_size_o}, {61'h0, m_size});
      chk1($sformatf("rnd%0d if_valid", c), bus.if_valid_o, e_iv);
      chk1($sformatf("rnd%0d ls_valid", c), bus.ls_valid_o, e_lv);
      chk64($sformatf("rnd%0d if_rdata", c), bus.if_rdata_o, e_ifrd);
      chk64($sformatf("rnd%0d ls_rdata", c), bus.ls_rdata_o, m_lsrd);

      if (act && !t_ls && !t_rdy) t_flush = t_flush | fl;
      if (act && !t_rdy && (c >= t_g + 2) && rdy) begin
        t_rdy = 1'b1; t_r = c; t_data = dat;
        if (t_ls && !t_wen) m_lsrd = dat;
      end
      if (e_resp) begin
        if (e_iv) m_ifrd = t_data;
        act = 1'b0;
      end
      if (e_ig || e_lg) begin
        act = 1'b1; t_ls = e_lg; t_g = c; t_rdy = 1'b0; last_ls = e_lg;
        t_flush = e_ig && fl;
        if (e_lg) begin
          t_wen = bus.ls_wen_i; m_addr = bus.ls_addr_i; m_wdata = bus.ls_wdata_i;
          m_wmask = bus.ls_wmask_i; m_size = bus.ls_size_i; lr = 1'b0;
        end else begin
          t_wen = 1'b0; m_addr = bus.if_addr_i; m_wdata = 64'h0;
          m_wmask = 8'h00; m_size = IF_SZ; ir = 1'b0;
        end
      end
      next();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter IF_SIZE, default 3'd2, RAM access size driven for instruction fetches.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port if_req_i  input  1  fetch request, held until granted.
REQ-005 SHALL have port if_addr_i  input  64  fetch byte address.
REQ-006 SHALL have port if_flush_i  input  1  redirect; drop any outstanding fetch response.
REQ-007 SHALL have port if_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_valid_o  output  1  one-cycle fetch response strobe.
REQ-009 SHALL have port if_rdata_o  output  64  fetch read data.
REQ-010 SHALL have ports ls_req_i  input  1, ls_wen_i  input  1, ls_addr_i  input  64, ls_wdata_i  input  64, ls_wmask_i  input  8, ls_size_i  input  3: load/store request, write flag, address, write data, byte mask, size.
REQ-011 SHALL have ports ls_gnt_o  output  1, ls_valid_o  output  1, ls_rdata_o  output  64: load/store grant, response strobe, read data.
REQ-012 SHALL have ports ram_rw_cen_o  output  1, ram_rw_wen_o  output  1, ram_rw_addr_o  output  64, ram_rw_wdata_o  output  64, ram_rw_wmask_o  output  8, ram_rw_size_o  output  3: shared RAM port.
REQ-013 SHALL have ports ram_rw_ready_i  input  1, ram_rw_data_i  input  64: RAM completion and read data.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding.
REQ-015 IDLE: requests pending -> grant one (combinational gnt_o, same cycle), latch its addr/wdata/wmask/size/wen and owner, go ISSUE; none -> stay IDLE.
REQ-016 Fetch transactions SHALL use wen=0, wmask=8'h00, size=IF_SIZE.
REQ-017 ISSUE: ram_rw_cen_o=1 and ram_rw_wen_o=latched wen for exactly this one cycle, then WAIT; cen SHALL be 0 in all other states.
REQ-018 ram_rw_addr_o/wdata_o/wmask_o/size_o SHALL be registered, updated only on grant, held otherwise.
REQ-019 WAIT: ram_rw_ready_i=1 -> latch ram_rw_data_i (reads only) into owner's rdata register, go RESP; else stay WAIT (no timeout).
REQ-020 RESP: owner's valid_o=1 for one cycle, then IDLE; no grant issued in RESP.
REQ-021 Latency: req granted cycle N -> cen N+1 -> ready earliest N+2 -> valid N+3; max throughput one transaction per 4 cycles.
REQ-022 ram_rw_ready_i outside WAIT SHALL be ignored.
REQ-023 Writes SHALL produce ls_valid_o but SHALL leave ls_rdata_o unchanged.
REQ-024 if_rdata_o/ls_rdata_o SHALL hold last read value until next read response for that requester.
REQ-025 if_flush_i high in any cycle from fetch grant through RESP inclusive -> RAM access completes normally, if_valid_o suppressed, if_rdata_o not updated.
REQ-026 if_flush_i SHALL have no effect on load/store transactions or on grant decisions.
REQ-027 Simultaneous if_req_i and ls_req_i in IDLE: arbitration per REQ-031/032; loser gets no gnt and retries next IDLE.

Reset
REQ-028 rst_n=0 at posedge clk -> state IDLE, all outputs 0, rdata registers 0, last-grant register = IF.
REQ-029 Reset mid-transaction SHALL abandon it; no valid_o for it; late ram_rw_ready_i ignored per REQ-022.
REQ-030 gnt_o SHALL be 0 while rst_n=0.

Configuration
REQ-031 Macro RAM_ARB_RR_EN undefined: fixed priority, LSU over IFU on conflict.
REQ-032 RAM_ARB_RR_EN defined: round-robin on conflict, grant requester not granted last; last-grant updates on every grant; first conflict after reset goes to LSU.

Verification
REQ-033 Single fetch: if_req_i=1, if_addr_i=0x8000_0000, ready_i one cycle after cen with data 0x0000_0013_0000_0093 -> if_gnt_o cycle 0, cen+addr cycle 1, if_valid_o cycle 3 with that data.
REQ-034 Store: ls_wen_i=1, addr 0x8000_0100, wdata 0x1122_3344_5566_7788, wmask 0xFF -> cen=wen=1 one cycle with those values; ls_valid_o pulses; ls_rdata_o unchanged.
REQ-035 Conflict: both requests held 3 transactions -> default build grants LS,LS,LS; RAM_ARB_RR_EN build grants LS,IF,LS.
REQ-036 Flush: fetch granted, if_flush_i=1 in WAIT -> cen still issued once, if_valid_o stays 0, next fetch returns normally.
REQ-037 Reset in WAIT: rst_n=0 one cycle, ready_i=1 next cycle -> no valid_o, all outputs 0, FSM IDLE.
REQ-038 Delayed ready: ready_i held 0 for 5 cycles after cen -> FSM stays WAIT, no new grant, cen not reasserted, valid_o one cycle after ready.
